seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
- Parametrised sequential shift-add multiplier; next generation of the fixed-width textbook datapath/controller multiplier.
- Adds WIDTH generalisation, a runtime signed/unsigned mode, a one-cycle done pulse, and an optional zero-operand fast path.
- Sits behind a start/rdy handshake as a shared arithmetic unit for small controllers; one multiply in flight at a time.

Parameters:
- WIDTH, 5, operand width in bits (legal: WIDTH >= 2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter P (derived, not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only while rdy=1.
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned. Latched with operands.
- multiplicand  input  WIDTH  operand B; latched on accepted start.
- multiplier  input  WIDTH  operand Q; latched on accepted start.
- product  output  2*WIDTH  result {A,Q}; valid when rdy=1 after a completed operation.
- rdy  output  1  1 = idle, accepting start.
- done  output  1  one-cycle pulse on the cycle product first becomes valid.
- state  output  2  FSM state encoding, for bench visibility.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, product=0, rdy=1, done=0, P=0, all internal regs 0. Overrides any operation in progress; no done pulse is generated.
- States: IDLE=2'b00, ADD=2'b01, SHIFT=2'b10; 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE: rdy=1.
  - On start=1: latch B, Q and mode; clear A and C; set P=WIDTH; go to ADD.
  - rdy=0 from the following cycle.
- ADD:
  - If Q[0]=1: unsigned mode does {C,A} = A + B. Signed mode uses a WIDTH+1-bit sign-extended accumulator, adding B, except when P==1 (final bit), where it subtracts B.
  - If Q[0]=0: accumulator unchanged.
  - P decrements by 1; go to SHIFT.
- SHIFT:
  - {C,A,Q} shifts right by 1. Unsigned: C=0 enters the MSB. Signed: arithmetic shift, sign of the WIDTH+1-bit accumulator is replicated.
  - If P==0: go to IDLE, assert done for that cycle, rdy=1. Otherwise go to ADD.
- Latency: start accepted at edge k -> product valid, rdy=1, done=1 after edge k+2*WIDTH.
- product:
  - Updates only at completion and holds until the next completion or reset.
  - Internal A/Q are not visible on product mid-operation.
- start while rdy=0 is ignored; it is not queued.
- Operand and signed_mode changes after acceptance have no effect.
- start held high continuously: a new operation is accepted on the done cycle, giving back-to-back operations every 2*WIDTH+1 cycles.
- Arithmetic:
  - Unsigned product is exact for all 2^(2*WIDTH) operand pairs.
  - Signed product is exact two's complement, including (-2^(WIDTH-1))^2.
  - No overflow is possible.

Optional Feature:
- Macro: SEQ_MULT_ZERO_SKIP_EN.
- Defined: if an accepted start has multiplicand==0 or multiplier==0, the FSM stays in IDLE. At the next edge it sets product=0 and pulses done, with rdy held at 1 throughout. Latency is 1 cycle.
- Undefined: zero operands take the full 2*WIDTH cycles and product=0. The cycle-level behaviour is identical to any other operand pair.

Test Plan:
- WIDTH=5, unsigned, 23 x 19 -> product=10'd437 (0x1B5); done pulses exactly once, 10 cycles after the start edge; rdy low for 10 cycles.
- WIDTH=5, signed, -9 (5'b10111) x 19 (5'b10011, read as -13) -> product=10'd117; unsigned mode with the same bits -> 437.
- WIDTH=5, signed, -16 x -16 -> 10'h100; unsigned, 31 x 31 -> 10'h3C1.
- Exhaustive WIDTH=5 sweep, all 1024 pairs in both modes, with start held high -> each product matches the reference model. Operations are spaced 11 cycles apart.
- rst asserted on the 4th cycle of an operation -> next edge: state=IDLE, rdy=1, product=0, no done. A new start then yields a correct result.
- 0 x 17, each build, checking done and rdy: with SEQ_MULT_ZERO_SKIP_EN, product=0 and done one cycle after start, rdy never low. Without it, product=0 after 10 cycles. WIDTH=8 unsigned 255 x 255 -> 16'hFE01 after 16 cycles.

Source files
------------

// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised sequential shift-add multiplier.
// One multiply in flight at a time, behind a start/rdy handshake.
// The operands are WIDTH bits wide and the product is 2*WIDTH bits wide.
// signed_mode selects two's-complement or unsigned arithmetic for each operation.
// A completed multiply takes 2*WIDTH cycles and ends with a one-cycle done pulse.
// Optional build macro SEQ_MULT_ZERO_SKIP_EN: a start with a zero operand
// completes from IDLE without running the add/shift sequence.
module seq_mult_param #(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 rdy,
  output logic                 done,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t             st;
  logic [WIDTH:0]     acc;      // {C,A}; in signed mode a sign-extended accumulator
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [CNT_W-1:0]   p_cnt;
  logic               mode_reg;

  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     acc_add;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               shift_in;
  logic               zero_op;

  assign state = st;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next accumulator values for the ADD step and for the right shift of {A,Q}.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    b_ext    = mode_reg ? {b_reg[WIDTH-1], b_reg} : {1'b0, b_reg};
    acc_add  = acc;
    if (q_reg[0]) begin
      // The final multiplier bit of a two's-complement operand carries negative weight.
      if (mode_reg && (p_cnt == CNT_W'(1)))
        acc_add = acc - b_ext;
      else
        acc_add = acc + b_ext;
    end
    shift_in = mode_reg & acc[WIDTH];
    acc_sh   = {shift_in, acc[WIDTH:1]};
    q_sh     = {acc[0], q_reg[WIDTH-1:1]};
  end

  // Controller FSM and datapath registers. The outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      st       <= IDLE;
      acc      <= '0;
      b_reg    <= '0;
      q_reg    <= '0;
      p_cnt    <= '0;
      mode_reg <= 1'b0;
      product  <= '0;
      rdy      <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          rdy <= 1'b1;
          if (start) begin
            if (zero_op) begin
              // Zero fast path: the result is known, so the FSM stays idle.
              product <= '0;
              done    <= 1'b1;
            end else begin
              b_reg    <= multiplicand;
              q_reg    <= multiplier;
              mode_reg <= signed_mode;
              acc      <= '0;
              p_cnt    <= CNT_W'(WIDTH);
              rdy      <= 1'b0;
              st       <= ADD;
            end
          end
        end
        ADD: begin
          acc   <= acc_add;
          p_cnt <= p_cnt - CNT_W'(1);
          st    <= SHIFT;
        end
        SHIFT: begin
          acc   <= acc_sh;
          q_reg <= q_sh;
          if (p_cnt == '0) begin
            product <= {acc_sh[WIDTH-1:0], q_sh};
            done    <= 1'b1;
            rdy     <= 1'b1;
            st      <= IDLE;
          end else begin
            st <= ADD;
          end
        end
        default: begin
          // The unused encoding returns to IDLE.
          rdy <= 1'b1;
          st  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: randomized and directed checks of seq_mult_param
// against an arithmetic reference model (WIDTH=5 and WIDTH=8 instances).
module tb_seq_mult_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [4:0]  multiplicand;
  logic [4:0]  multiplier;
  logic [9:0]  product;
  logic        rdy;
  logic        done;
  logic [1:0]  state;

  logic        start8;
  logic        signed_mode8;
  logic [7:0]  multiplicand8;
  logic [7:0]  multiplier8;
  logic [15:0] product8;
  logic        rdy8;
  logic        done8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_param #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .rdy(rdy), .done(done), .state(state)
  );

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(signed_mode8),
    .multiplicand(multiplicand8), .multiplier(multiplier8),
    .product(product8), .rdy(rdy8), .done(done8), .state(state8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef SEQ_MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  // Reference: the product of two w-bit numbers, read as unsigned or two's complement,
  // reduced modulo 2^(2w).
  function automatic longint ref_mult(longint a, longint b, bit s, int w);
    longint sa, sb, half, full;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
    sa = a;
    sb = b;
    if (s) begin
      if (a >= half) sa = a - full;
      if (b >= half) sb = b - full;
    end
    return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=5 operation and checks the result, the latency, rdy and the done pulse.
  // With disturb=1 the inputs change, and start toggles, while the unit is busy.
  task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic s,
                       input bit disturb, input string name);
    logic [9:0] exp_p;
    int exp_lat, cycles, rdy_low;
    exp_p   = 10'(ref_mult(a, b, s, 5));
    exp_lat = (ZERO_SKIP && (a == 0 || b == 0)) ? 0 : 10;
    multiplicand = a; multiplier = b; signed_mode = s; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0; rdy_low = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (rdy === 1'b0) rdy_low++;
      if (disturb) begin
        multiplicand = 5'($urandom); multiplier = 5'($urandom);
        signed_mode = 1'($urandom); start = 1'($urandom);
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    n_checks++;
    if (cycles != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cycles, exp_lat);
    end
    n_checks++;
    if (rdy_low != exp_lat) begin
      n_fail++;
      $display("FAIL %s rdy_low: got %0d cycles, expected %0d", name, rdy_low, exp_lat);
    end
    n_checks++;
    if (product !== exp_p) begin
      n_fail++;
      $display("FAIL %s product: got 0x%0h, expected 0x%0h", name, product, exp_p);
    end
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rdy_at_done: got %b, expected 1", name, rdy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || product !== exp_p) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b product=0x%0h, expected done=0 product=0x%0h",
               name, done, product, exp_p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    signed_mode8 = 1'b0; multiplicand8 = '0; multiplier8 = '0;
    tick(); tick();
    n_checks++;
    if (state !== 2'b00 || rdy !== 1'b1 || done !== 1'b0 || product !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_w5: state=%b rdy=%b done=%b product=0x%0h, expected 00 1 0 0x0",
               state, rdy, done, product);
    end
    n_checks++;
    if (state8 !== 2'b00 || rdy8 !== 1'b1 || done8 !== 1'b0 || product8 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_w8: state=%b rdy=%b done=%b product=0x%0h, expected 00 1 0 0x0",
               state8, rdy8, done8, product8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    do_op(5'd23, 5'd19, 1'b0, 1'b0, "u23x19");
    n_checks++;
    if (product !== 10'd437) begin
      n_fail++;
      $display("FAIL u23x19_const: got %0d, expected 437", product);
    end
    do_op(5'b10111, 5'b10011, 1'b1, 1'b0, "s-9x-13");
    n_checks++;
    if (product !== 10'd117) begin
      n_fail++;
      $display("FAIL s-9x-13_const: got %0d, expected 117", product);
    end
    do_op(5'b10000, 5'b10000, 1'b1, 1'b0, "s-16x-16");
    n_checks++;
    if (product !== 10'h100) begin
      n_fail++;
      $display("FAIL s-16x-16_const: got 0x%0h, expected 0x100", product);
    end
    do_op(5'd31, 5'd31, 1'b0, 1'b0, "u31x31");
    n_checks++;
    if (product !== 10'h3C1) begin
      n_fail++;
      $display("FAIL u31x31_const: got 0x%0h, expected 0x3C1", product);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_op(5'($urandom), 5'($urandom), 1'($urandom), 1'b1, "random");
  endtask

  task automatic test_zero();
    int rdy_low;
    do_op(5'd0, 5'd17, 1'b0, 1'b0, "zero_0x17");
    do_op(5'd17, 5'd0, 1'b1, 1'b0, "zero_17x0");
    // With start held high, zero operands repeat; rdy must match the build's behaviour.
    rdy_low = 0;
    multiplicand = 5'd0; multiplier = 5'd17; signed_mode = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rdy === 1'b0) rdy_low++;
    end
    start = 1'b0;
    n_checks++;
    if (ZERO_SKIP ? (rdy_low != 0) : (rdy_low == 0)) begin
      n_fail++;
      $display("FAIL zero_rdy_held: rdy low for %0d cycles, skip build=%0d", rdy_low, ZERO_SKIP);
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_back_to_back();
    logic [10:0] nxt;
    logic [9:0]  exp_p;
    int cycles, exp_lat;
    bit aborted;
    aborted = 1'b0;
    multiplicand = 5'd0; multiplier = 5'd0; signed_mode = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 2048 && !aborted; i++) begin
      logic [10:0] cur;
      cur = 11'(i);
      nxt = 11'(i + 1);
      signed_mode = nxt[10]; multiplicand = nxt[9:5]; multiplier = nxt[4:0];
      exp_p   = 10'(ref_mult(cur[9:5], cur[4:0], cur[10], 5));
      exp_lat = (ZERO_SKIP && (cur[9:5] == 0 || cur[4:0] == 0)) ? 0 : 10;
      cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
        tick();
        cycles++;
      end
      if (i == 2047) start = 1'b0;
      n_checks++;
      if (cycles != exp_lat) begin
        n_fail++;
        $display("FAIL b2b_latency op %0d: got %0d cycles, expected %0d", i, cycles, exp_lat);
        if (cycles >= 40) aborted = 1'b1;
      end
      n_checks++;
      if (product !== exp_p) begin
        n_fail++;
        $display("FAIL b2b_product op %0d (mode %b %0d x %0d): got 0x%0h, expected 0x%0h",
                 i, cur[10], cur[9:5], cur[4:0], product, exp_p);
      end
      tick();
    end
    start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    multiplicand = 5'd23; multiplier = 5'd19; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (state !== 2'b00 || rdy !== 1'b1 || product !== 10'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: state=%b rdy=%b done=%b product=0x%0h, expected 00 1 0 0x0",
               state, rdy, done, product);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1 || rdy !== 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_op_quiet: got done or rdy=0 after reset, expected idle");
    end
    do_op(5'd23, 5'd19, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_width8();
    logic [7:0]  a [3];
    logic [7:0]  b [3];
    logic        s [3];
    logic [15:0] exp_p;
    int cycles;
    a[0] = 8'd255; b[0] = 8'd255; s[0] = 1'b0;
    a[1] = 8'h80;  b[1] = 8'h80;  s[1] = 1'b1;
    a[2] = 8'($urandom); b[2] = 8'($urandom | 1); s[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_p = 16'(ref_mult(a[k], b[k], s[k], 8));
      multiplicand8 = a[k]; multiplier8 = b[k]; signed_mode8 = s[k]; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      cycles = 0;
      while (done8 !== 1'b1 && cycles < 60) begin
        tick();
        cycles++;
      end
      n_checks++;
      if (cycles != 16) begin
        n_fail++;
        $display("FAIL w8_latency case %0d: got %0d cycles, expected 16", k, cycles);
      end
      n_checks++;
      if (product8 !== exp_p) begin
        n_fail++;
        $display("FAIL w8_product case %0d: got 0x%0h, expected 0x%0h", k, product8, exp_p);
      end
      tick();
    end
    n_checks++;
    if (product8 !== 16'(ref_mult(a[2], b[2], s[2], 8)) || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_hold: product=0x%0h done=%b", product8, done8);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
